// File: rtl/munoc_svring_request_arbiter.sv
// munoc_svring_request_arbiter
//   Round-robin arbiter that shares one service-ring request port among
//   NUM_REQ APB-style requesters. The winner's payload is latched and held
//   on the req_* bus until the controller strobes req_ready. A watchdog
//   completes a stalled request towards the requester with SLVERR. The
//   arbiter then waits in DRAIN and discards the late controller response.
//
// Ports
//   clk, rstnn                     clock, async active-low reset
//   rpsel/rpenable/rpwrite         per-requester APB control
//   rpaddr/rpwdata/rpmid           packed per-requester payload, requester i at [i*W +: W]
//   rprdata                        read data broadcast to all requesters
//   rpready/rpslverr               per-requester completion / error
//   req_valid/addr/write/wdata/mid latched request to the svring controller
//   req_ready/rdata/slverr         controller completion strobe and response
//   timeout_pulse                  1-cycle pulse when the watchdog fires
module munoc_svring_request_arbiter #(
  parameter int NUM_REQ           = 2,
  parameter int BW_PLATFORM_ADDR  = 32,
  parameter int BW_DATA           = 32,
  parameter int BW_MASTER_NODE_ID = 4,
  parameter int TIMEOUT_CYCLES    = 256
) (
  input  logic                                   clk,
  input  logic                                   rstnn,
  input  logic [NUM_REQ-1:0]                     rpsel,
  input  logic [NUM_REQ-1:0]                     rpenable,
  input  logic [NUM_REQ*BW_PLATFORM_ADDR-1:0]    rpaddr,
  input  logic [NUM_REQ-1:0]                     rpwrite,
  input  logic [NUM_REQ*BW_DATA-1:0]             rpwdata,
  input  logic [NUM_REQ*BW_MASTER_NODE_ID-1:0]   rpmid,
  output logic [BW_DATA-1:0]                     rprdata,
  output logic [NUM_REQ-1:0]                     rpready,
  output logic [NUM_REQ-1:0]                     rpslverr,
  output logic                                   req_valid,
  output logic [BW_PLATFORM_ADDR-1:0]            req_addr,
  output logic                                   req_write,
  output logic [BW_DATA-1:0]                     req_wdata,
  output logic [BW_MASTER_NODE_ID-1:0]           req_mid,
  input  logic                                   req_ready,
  input  logic [BW_DATA-1:0]                     req_rdata,
  input  logic                                   req_slverr,
  output logic                                   timeout_pulse
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  typedef struct packed {
    logic [BW_PLATFORM_ADDR-1:0]  addr;
    logic                         write;
    logic [BW_DATA-1:0]           wdata;
    logic [BW_MASTER_NODE_ID-1:0] mid;
  } req_t;

  // Packed 2-D views share the flat bus layout: element i == [i*W +: W].
  logic [NUM_REQ-1:0][BW_PLATFORM_ADDR-1:0]  addr_v;
  logic [NUM_REQ-1:0][BW_DATA-1:0]           wdata_v;
  logic [NUM_REQ-1:0][BW_MASTER_NODE_ID-1:0] mid_v;

  assign addr_v  = rpaddr;
  assign wdata_v = rpwdata;
  assign mid_v   = rpmid;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, gnt, gnt_nxt;
  logic [TW-1:0]     timer;
  req_t              req_q;
  logic [NUM_REQ-1:0] pend, rot;
  logic [2*NUM_REQ-1:0] pend2;
  logic              any_pend, wd_fire;

  assign pend     = rpsel & rpenable;
  assign any_pend = |pend;
  assign pend2    = {pend, pend};

  // Rotate pending so bit 0 is the requester right after the last grant;
  // the lowest set bit of rot is the winner. Descending scan leaves the
  // closest one in gnt_nxt.
  always_comb begin
    rot     = NUM_REQ'(pend2 >> (int'(ptr) + 1));
    gnt_nxt = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) gnt_nxt = PW'((int'(ptr) + 1 + j) % NUM_REQ);
    end
  end

  assign wd_fire = (TIMEOUT_CYCLES != 0) && (timer == TLIM);

  // Next state and requester-side response. req_ready takes precedence over
  // a coincident watchdog expiry.
  always_comb begin
    state_nxt     = state;
    rpready       = '0;
    rpslverr      = '0;
    rprdata       = '0;
    timeout_pulse = 1'b0;
    case (state)
      IDLE:  if (any_pend) state_nxt = BUSY;
      BUSY: begin
        if (req_ready) begin
          rpready[gnt]  = 1'b1;
          rpslverr[gnt] = req_slverr;
          rprdata       = req_rdata;
          state_nxt     = IDLE;
        end else if (wd_fire) begin
          rpready[gnt]  = 1'b1;
          rpslverr[gnt] = 1'b1;
          timeout_pulse = 1'b1;
          state_nxt     = DRAIN;
        end
      end
      // Late controller response is swallowed; requester already released.
      DRAIN: if (req_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state <= IDLE;
      ptr   <= PW'(NUM_REQ - 1);
      gnt   <= '0;
      timer <= '0;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_pend) begin
        gnt         <= gnt_nxt;
        ptr         <= gnt_nxt;
        timer       <= '0;
        req_q.addr  <= addr_v[gnt_nxt];
        req_q.write <= rpwrite[gnt_nxt];
        req_q.wdata <= wdata_v[gnt_nxt];
        req_q.mid   <= mid_v[gnt_nxt];
      end else if (state == BUSY && TIMEOUT_CYCLES != 0) begin
        timer <= timer + TW'(1);
      end
    end
  end

  assign req_valid = (state != IDLE);
  assign req_addr  = req_q.addr;
  assign req_write = req_q.write;
  assign req_wdata = req_q.wdata;
  assign req_mid   = req_q.mid;

endmodule

// File: tb/tb_munoc_svring_request_arbiter.sv
module tb_munoc_svring_request_arbiter;
  localparam int N = 2, AW = 32, DW = 32, MW = 4, TO = 8;

  logic            clk, rstnn;
  logic [N-1:0]    rpsel, rpenable, rpwrite, rpready, rpslverr;
  logic [N*AW-1:0] rpaddr;
  logic [N*DW-1:0] rpwdata;
  logic [N*MW-1:0] rpmid;
  logic [DW-1:0]   rprdata, req_wdata, req_rdata;
  logic [AW-1:0]   req_addr;
  logic [MW-1:0]   req_mid;
  logic            req_valid, req_write, req_ready, req_slverr, timeout_pulse;

  munoc_svring_request_arbiter #(
    .NUM_REQ(N), .BW_PLATFORM_ADDR(AW), .BW_DATA(DW),
    .BW_MASTER_NODE_ID(MW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstnn(rstnn), .rpsel(rpsel), .rpenable(rpenable),
    .rpaddr(rpaddr), .rpwrite(rpwrite), .rpwdata(rpwdata), .rpmid(rpmid),
    .rprdata(rprdata), .rpready(rpready), .rpslverr(rpslverr),
    .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_mid(req_mid), .req_ready(req_ready),
    .req_rdata(req_rdata), .req_slverr(req_slverr), .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  sel, en;
    logic        rdy;
    logic [31:0] rdata;
    logic        serr;
    logic        ev;
    logic [31:0] ea;
    logic [1:0]  erp, ese;
    logic [31:0] erd;
    logic        eto;
  } vec_t;

  vec_t vq[$];
  int   nvec = 0, nerr = 0;

  task automatic add(input logic rst, input logic [1:0] sel, input logic [1:0] en,
                     input logic rdy, input logic [31:0] rdata, input logic serr,
                     input logic ev, input logic [31:0] ea, input logic [1:0] erp,
                     input logic [1:0] ese, input logic [31:0] erd, input logic eto);
    vec_t v;
    v.rst = rst; v.sel = sel; v.en = en; v.rdy = rdy; v.rdata = rdata; v.serr = serr;
    v.ev = ev; v.ea = ea; v.erp = erp; v.ese = ese; v.erd = erd; v.eto = eto;
    vq.push_back(v);
  endtask

  // Fixed requester payloads: req0 writes 0x40, req1 reads 0x80.
  task automatic check_vec(input int i, input vec_t v);
    logic        ok;
    logic [31:0] ew;
    logic [3:0]  em;
    logic        ewr;
    ew  = (v.ea == 32'h40) ? 32'hA5A5_0001 : 32'h5A5A_0002;
    em  = (v.ea == 32'h40) ? 4'd3 : 4'd7;
    ewr = (v.ea == 32'h40);
    ok = (req_valid === v.ev) && (rpready === v.erp) && (rpslverr === v.ese) &&
         (rprdata === v.erd) && (timeout_pulse === v.eto);
    if (v.ev)
      ok = ok && (req_addr === v.ea) && (req_wdata === ew) && (req_mid === em) && (req_write === ewr);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL vec%0d: got valid=%b addr=%h wd=%h mid=%h wr=%b rpready=%b slverr=%b rdata=%h to=%b; want valid=%b addr=%h wd=%h mid=%h wr=%b rpready=%b slverr=%b rdata=%h to=%b",
               i, req_valid, req_addr, req_wdata, req_mid, req_write, rpready, rpslverr, rprdata, timeout_pulse,
               v.ev, v.ea, ew, em, ewr, v.erp, v.ese, v.erd, v.eto);
    end
  endtask

  initial begin
    rstnn = 1'b0; rpsel = '0; rpenable = '0;
    rpaddr  = {32'h0000_0080, 32'h0000_0040};
    rpwdata = {32'h5A5A_0002, 32'hA5A5_0001};
    rpmid   = {4'd7, 4'd3};
    rpwrite = 2'b01;
    req_ready = 1'b0; req_rdata = '0; req_slverr = 1'b0;

    // Single write, req_ready 4 cycles after the access phase
    add(0,2'b00,2'b00,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b01,2'b00,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b01,2'b01,0,0,0, 0,0,2'b00,2'b00,0,0);
    for (int k = 0; k < 3; k++) add(0,2'b01,2'b01,0,0,0, 1,32'h40,2'b00,2'b00,0,0);
    add(0,2'b01,2'b01,1,32'hDEAD_BEEF,0, 1,32'h40,2'b01,2'b00,32'hDEAD_BEEF,0);
    add(0,2'b00,2'b00,0,0,0, 0,0,2'b00,2'b00,0,0);
    // Round-robin after reset; read with slverr
    add(1,2'b00,2'b00,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b11,2'b00,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b11,2'b11,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b11,2'b11,0,0,0, 1,32'h40,2'b00,2'b00,0,0);
    add(0,2'b11,2'b11,1,0,0, 1,32'h40,2'b01,2'b00,0,0);
    add(0,2'b11,2'b10,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b11,2'b11,0,0,0, 1,32'h80,2'b00,2'b00,0,0);
    add(0,2'b11,2'b11,1,32'h1234_5678,1, 1,32'h80,2'b10,2'b10,32'h1234_5678,0);
    add(0,2'b11,2'b01,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b11,2'b11,0,0,0, 1,32'h40,2'b00,2'b00,0,0);
    add(0,2'b11,2'b11,1,32'h55,0, 1,32'h40,2'b01,2'b00,32'h55,0);
    add(0,2'b11,2'b10,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b11,2'b10,0,0,0, 1,32'h80,2'b00,2'b00,0,0);
    add(0,2'b11,2'b11,1,0,0, 1,32'h80,2'b10,2'b00,0,0);
    add(0,2'b00,2'b00,0,0,0, 0,0,2'b00,2'b00,0,0);
    // Watchdog fires on 8th BUSY cycle, late response drained
    add(0,2'b01,2'b01,0,0,0, 0,0,2'b00,2'b00,0,0);
    for (int k = 0; k < 7; k++) add(0,2'b01,2'b01,0,0,0, 1,32'h40,2'b00,2'b00,0,0);
    add(0,2'b01,2'b01,0,0,0, 1,32'h40,2'b01,2'b01,0,1);
    for (int k = 0; k < 4; k++) add(0,2'b00,2'b00,0,0,0, 1,32'h40,2'b00,2'b00,0,0);
    add(0,2'b00,2'b00,1,32'hFFFF,0, 1,32'h40,2'b00,2'b00,0,0);
    add(0,2'b10,2'b10,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b10,2'b10,1,32'hAB,0, 1,32'h80,2'b10,2'b00,32'hAB,0);
    add(0,2'b00,2'b00,0,0,0, 0,0,2'b00,2'b00,0,0);
    // req_ready coincides with the watchdog limit
    add(0,2'b01,2'b01,0,0,0, 0,0,2'b00,2'b00,0,0);
    for (int k = 0; k < 7; k++) add(0,2'b01,2'b01,0,0,0, 1,32'h40,2'b00,2'b00,0,0);
    add(0,2'b01,2'b01,1,32'h77,1, 1,32'h40,2'b01,2'b01,32'h77,0);
    add(0,2'b00,2'b00,0,0,0, 0,0,2'b00,2'b00,0,0);
    // Reset mid-BUSY: req_valid drops before the next edge, req0 first after
    add(0,2'b01,2'b01,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b01,2'b01,0,0,0, 1,32'h40,2'b00,2'b00,0,0);
    add(1,2'b01,2'b01,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b11,2'b00,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b11,2'b11,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b11,2'b11,0,0,0, 1,32'h40,2'b00,2'b00,0,0);
    add(0,2'b11,2'b11,1,0,0, 1,32'h40,2'b01,2'b00,0,0);
    add(0,2'b10,2'b10,0,0,0, 0,0,2'b00,2'b00,0,0);
    add(0,2'b10,2'b10,1,0,0, 1,32'h80,2'b10,2'b00,0,0);
    add(0,2'b00,2'b00,0,0,0, 0,0,2'b00,2'b00,0,0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    nvec++;
    if (req_valid !== 1'b0 || req_addr !== '0 || req_wdata !== '0 || req_mid !== '0 ||
        req_write !== 1'b0 || rpready !== '0 || rpslverr !== '0 || rprdata !== '0 ||
        timeout_pulse !== 1'b0) begin
      nerr++;
      $display("FAIL reset: got valid=%b addr=%h wd=%h mid=%h wr=%b rpready=%b slverr=%b rdata=%h to=%b; want all zero",
               req_valid, req_addr, req_wdata, req_mid, req_write, rpready, rpslverr, rprdata, timeout_pulse);
    end

    foreach (vq[i]) begin
      @(negedge clk);
      rstnn     = !vq[i].rst;
      rpsel     = vq[i].sel;
      rpenable  = vq[i].en;
      req_ready = vq[i].rdy;
      req_rdata = vq[i].rdata;
      req_slverr = vq[i].serr;
      #1;
      check_vec(i, vq[i]);
    end

    // Bounded wait for a lone req1 grant, then complete it
    begin
      bit got;
      got = 1'b0;
      @(negedge clk);
      rpsel = 2'b10; rpenable = 2'b10; req_ready = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
        @(negedge clk); #1;
        if (req_valid === 1'b1) got = 1'b1;
      end
      nvec++;
      if (!got || req_addr !== 32'h80) begin
        nerr++;
        $display("FAIL wait_grant: got valid=%b addr=%h; want valid=1 addr=00000080", req_valid, req_addr);
      end
      @(negedge clk);
      req_ready = 1'b1; req_rdata = 32'hC0DE; req_slverr = 1'b0;
      #1;
      nvec++;
      if (rpready !== 2'b10 || rprdata !== 32'hC0DE || rpslverr !== 2'b00) begin
        nerr++;
        $display("FAIL wait_done: got rpready=%b rdata=%h slverr=%b; want 10 0000c0de 00", rpready, rprdata, rpslverr);
      end
      @(negedge clk);
      req_ready = 1'b0; rpsel = '0; rpenable = '0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
